// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO key reporting block.
package gpio_pkg;

  // Per-channel debounce FSM state.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } key_fsm_e;

  // Default qualification length in sclk cycles.
  localparam int unsigned DB_CYCLES_DEFAULT = 32'd1000000;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce FSM and qualification counter.
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | key released and qualified as released
// PRESS_DB   | key seen pressed, counting stable-pressed cycles
// PRESSED    | key qualified as pressed
// RELEASE_DB | key seen released, counting stable-released cycles
module key_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic sclk,
  input  logic rst,
  input  logic key_n_i,
  output logic key_state_o,
  output logic qualify_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed;
  key_fsm_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_state_q;

  // Bring the raw pin into the sclk domain; reset value means released.
  always_ff @(posedge sclk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // Debounce FSM; key_state is updated on the same edge the qualifying
  // transition is taken so it carries no extra cycle of latency.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_state_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_q <= ST_PRESS_DB;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_PRESSED;
            key_state_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end
        end
        ST_RELEASE_DB: begin
          if (pressed) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_IDLE;
            key_state_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          key_state_q <= 1'b0;
        end
      endcase
    end
  end

  // High in the cycle whose closing edge takes PRESS_DB -> PRESSED.
  assign qualify_o   = (state_q == ST_PRESS_DB) && pressed && (cnt_q == CNT_LAST);
  assign key_state_o = key_state_q;

endmodule

// File: rtl/gpio_key_report.sv
// Debounced key reporting to the ARM: per-key level, sticky press event, IRQ.
module gpio_key_report
  import gpio_pkg::*;
#(
  parameter int          NKEY      = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic            sclk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_n,
  input  logic [NKEY-1:0] arm_ack,
  output logic [NKEY-1:0] key_state,
  output logic [NKEY-1:0] key_evt,
  output logic            key_irq
);

  logic [NKEY-1:0] ack1_q;
  logic [NKEY-1:0] ack2_q;
  logic [NKEY-1:0] ack3_q;
  logic [NKEY-1:0] ack_rise;
  logic [NKEY-1:0] qualify;
  logic [NKEY-1:0] key_evt_d;
  logic [NKEY-1:0] key_evt_q;

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
      .sclk        (sclk),
      .rst         (rst),
      .key_n_i     (key_n[g]),
      .key_state_o (key_state[g]),
      .qualify_o   (qualify[g])
    );
  end

  // Synchronize the ARM acknowledges; the third flop provides edge detection.
  always_ff @(posedge sclk) begin
    if (rst) begin
      ack1_q <= '0;
      ack2_q <= '0;
      ack3_q <= '0;
    end else begin
      ack1_q <= arm_ack;
      ack2_q <= ack1_q;
      ack3_q <= ack2_q;
    end
  end

  assign ack_rise = ack2_q & ~ack3_q;

  // A new qualification beats a simultaneous acknowledge.
  always_comb begin
    key_evt_d = qualify | (key_evt_q & ~ack_rise);
  end

  // Sticky event flags.
  always_ff @(posedge sclk) begin
    if (rst) begin
      key_evt_q <= '0;
    end else begin
      key_evt_q <= key_evt_d;
    end
  end

  assign key_evt = key_evt_q;
  assign key_irq = |key_evt_q;

endmodule

// File: tb/tb_gpio_key_report.sv
// Self-checking bench for gpio_key_report with DB_CYCLES=4, NKEY=2.
module tb_gpio_key_report;

  localparam int          NKEY = 2;
  localparam int unsigned DB   = 4;

  logic            sclk = 1'b0;
  logic            rst;
  logic [NKEY-1:0] key_n;
  logic [NKEY-1:0] arm_ack;
  logic [NKEY-1:0] key_state;
  logic [NKEY-1:0] key_evt;
  logic            key_irq;

  int tests = 0;
  int fails = 0;

  // Reference model: sampled-input histories and run-length debounce.
  logic [1:0]      kh [NKEY];
  logic [2:0]      ah [NKEY];
  int              m_run [NKEY];
  logic [NKEY-1:0] m_deb = '0;
  logic [NKEY-1:0] m_evt = '0;

  always #5 sclk = ~sclk;

  gpio_key_report #(
    .NKEY      (NKEY),
    .DB_CYCLES (DB)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .key_n     (key_n),
    .arm_ack   (arm_ack),
    .key_state (key_state),
    .key_evt   (key_evt),
    .key_irq   (key_irq)
  );

  // Debounced level flips once the synchronized input has disagreed with it
  // for DB+1 consecutive edges; a flip to pressed raises the event, which is
  // otherwise cleared one edge after a synchronized acknowledge rise.
  function automatic void model_step();
    logic ks_pressed;
    logic arise;
    logic qual;
    if (rst) begin
      for (int i = 0; i < NKEY; i++) begin
        kh[i]    = 2'b11;
        ah[i]    = 3'b000;
        m_run[i] = 0;
      end
      m_deb = '0;
      m_evt = '0;
    end else begin
      for (int i = 0; i < NKEY; i++) begin
        ks_pressed = ~kh[i][1];
        arise      = ah[i][1] & ~ah[i][2];
        kh[i]      = {kh[i][0], key_n[i]};
        ah[i]      = {ah[i][1:0], arm_ack[i]};
        qual       = 1'b0;
        if (ks_pressed != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DB) + 1) begin
            m_deb[i] = ks_pressed;
            m_run[i] = 0;
            qual     = ks_pressed;
          end
        end else begin
          m_run[i] = 0;
        end
        if (qual) m_evt[i] = 1'b1;
        else if (arise) m_evt[i] = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge sclk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = '1; arm_ack = '0;
    repeat (3) tick();
    tests++; if (key_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b expected 00", key_state); end
    tests++; if (key_evt !== 2'b00) begin fails++; $display("FAIL reset_evt: got %b expected 00", key_evt); end
    tests++; if (key_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", key_irq); end
    rst = 1'b0;
    repeat (2) tick();
    tests++; if (key_state !== 2'b00 || key_evt !== 2'b00) begin fails++; $display("FAIL reset_idle: got state %b evt %b expected 00 00", key_state, key_evt); end
  endtask

  task automatic test_press();
    key_n[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        tests++; if (key_state !== 2'b00 || key_irq !== 1'b0) begin fails++; $display("FAIL press_early: edge 6 state %b irq %b expected 00 0", key_state, key_irq); end
      end
    end
    tests++; if (key_state !== 2'b01) begin fails++; $display("FAIL press_state: got %b expected 01", key_state); end
    tests++; if (key_evt !== 2'b01) begin fails++; $display("FAIL press_evt: got %b expected 01", key_evt); end
    tests++; if (key_irq !== 1'b1) begin fails++; $display("FAIL press_irq: got %b expected 1", key_irq); end
  endtask

  task automatic test_release_ack();
    int clr_edge;
    key_n[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        tests++; if (key_state[0] !== 1'b1) begin fails++; $display("FAIL release_early: got %b expected 1", key_state[0]); end
      end
    end
    tests++; if (key_state[0] !== 1'b0) begin fails++; $display("FAIL release_state: got %b expected 0", key_state[0]); end
    tests++; if (key_evt[0] !== 1'b1) begin fails++; $display("FAIL release_evt_kept: got %b expected 1", key_evt[0]); end
    arm_ack[0] = 1'b1;
    clr_edge = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 2) begin
        tests++; if (key_evt[0] !== 1'b1) begin fails++; $display("FAIL ack_early: edge 2 evt %b expected 1", key_evt[0]); end
      end
      if (clr_edge == 0 && key_evt[0] === 1'b0) clr_edge = e;
    end
    tests++; if (clr_edge == 0) begin fails++; $display("FAIL ack_clear: evt %b after 5 edges expected 0", key_evt[0]); end
    tests++; if (key_irq !== 1'b0) begin fails++; $display("FAIL ack_irq: got %b expected 0", key_irq); end
    arm_ack[0] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    key_n[0] = 1'b0;
    repeat (4) tick();
    key_n[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      tests++; if (key_state !== 2'b00 || key_evt !== 2'b00) begin fails++; $display("FAIL glitch: edge %0d state %b evt %b expected 00 00", e, key_state, key_evt); end
    end
  endtask

  task automatic test_ack_collision();
    key_n[1] = 1'b0;
    repeat (4) tick();
    arm_ack[1] = 1'b1;
    repeat (3) tick();
    tests++; if (key_state[1] !== 1'b1) begin fails++; $display("FAIL collide_state: got %b expected 1", key_state[1]); end
    tests++; if (key_evt[1] !== 1'b1) begin fails++; $display("FAIL collide_evt: got %b expected 1", key_evt[1]); end
    repeat (2) tick();
    tests++; if (key_evt[1] !== 1'b1 || key_evt[0] !== 1'b0) begin fails++; $display("FAIL collide_hold: got %b expected 10", key_evt); end
    arm_ack[1] = 1'b0;
    repeat (2) tick();
    arm_ack[1] = 1'b1;
    repeat (4) tick();
    tests++; if (key_evt[1] !== 1'b0) begin fails++; $display("FAIL collide_reack: got %b expected 0", key_evt[1]); end
    arm_ack[1] = 1'b0; key_n[1] = 1'b1;
    repeat (8) tick();
    tests++; if (key_state !== 2'b00) begin fails++; $display("FAIL collide_release: got %b expected 00", key_state); end
  endtask

  task automatic test_reset_mid();
    key_n[0] = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    tests++; if (key_state !== 2'b00 || key_evt !== 2'b00 || key_irq !== 1'b0) begin fails++; $display("FAIL midrst_clear: state %b evt %b irq %b expected 00 00 0", key_state, key_evt, key_irq); end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e <= 6) begin
        tests++; if (key_state[0] !== 1'b0 || key_evt[0] !== 1'b0) begin fails++; $display("FAIL midrst_early: edge %0d state %b evt %b expected 0 0", e, key_state[0], key_evt[0]); end
      end
    end
    tests++; if (key_state[0] !== 1'b1 || key_evt[0] !== 1'b1) begin fails++; $display("FAIL midrst_requal: state %b evt %b expected 1 1", key_state[0], key_evt[0]); end
  endtask

  task automatic test_release_bounce();
    key_n[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) key_n[0] = 1'b0;
      else key_n[0] = 1'b1;
      tick();
      if (e <= 9) begin
        tests++; if (key_state[0] !== 1'b1) begin fails++; $display("FAIL bounce_hold: edge %0d state %b expected 1", e, key_state[0]); end
      end
    end
    tests++; if (key_state[0] !== 1'b0) begin fails++; $display("FAIL bounce_release: got %b expected 0", key_state[0]); end
  endtask

  task automatic test_random();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NKEY; i++) begin
        if ($urandom_range(0, 7) == 0) key_n[i] = ~key_n[i];
        if ($urandom_range(0, 5) == 0) arm_ack[i] = ~arm_ack[i];
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      tests++; if (key_state !== m_deb) begin fails++; $display("FAIL rand_state: cycle %0d got %b expected %b", c, key_state, m_deb); end
      tests++; if (key_evt !== m_evt) begin fails++; $display("FAIL rand_evt: cycle %0d got %b expected %b", c, key_evt, m_evt); end
      tests++; if (key_irq !== (|m_evt)) begin fails++; $display("FAIL rand_irq: cycle %0d got %b expected %b", c, key_irq, |m_evt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_n = '1; arm_ack = '0;
    test_reset();
    test_press();
    test_release_ack();
    test_glitch();
    test_ack_collision();
    test_reset_mid();
    test_release_bounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
